// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   fetch_entry_t : {pc, instr} pair, the 32-bit view of one buffered fetch
//   NOP_INSTR     : instruction presented on Instr while nothing is buffered
//   fetch_state_t : FETCH (normal issue) / FLUSH (draining stale responses)
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small first-word-fall-through FIFO used both as the in-flight address queue
// and as the instruction buffer of inst_fetch_unit.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear (drops all entries, has priority over push)
//   push        : write push_data; accepted when not full, or full with pop
//   pop         : drop head entry (ignored when empty)
//   pop_data    : head entry (valid when !empty)
//   count       : occupancy 0..DEPTH
//   full, empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign pop_data = mem_reg[rd_ptr_reg];

  // A pop frees the head slot in the same cycle, so a full FIFO can still
  // take a write when it is being read.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage has no reset; the head is only observed when count is non-zero.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (push_ok && !clr && (wr_ptr_reg == AW'(gi)))
          mem_reg[gi] <= push_data;
      end
    end
  endgenerate

endmodule

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Decouples the program counter from instruction memory latency. Requests pass
// straight through to memory while credit is available; accepted addresses are
// queued and paired with in-order responses, then buffered for decode.
// Ports:
//   Clk_Core, Rst_Core_N            : clock, async active-low reset
//   Program_Count/_Valid/_Ready     : fetch request from the PC (stalls on !Ready)
//   Flush                           : redirect, discards buffered/in-flight work
//   Imem_Req_Valid/_Ready, Imem_Addr: memory request channel
//   Imem_Rsp_Valid, Imem_Rsp_Data   : in-order memory response, no backpressure
//   Instr_Valid/_Ready, Instr, Instr_PC : decode-side stream
//   Fetch_Misalign                  : sticky misaligned-PC flag
// Build option: define FETCH_MISALIGN_CHK_EN to enable misalignment checking;
// otherwise Program_Count[1:0] is not inspected and Fetch_Misalign is 0.
// -----------------------------------------------------------------------------
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int FETCH_DEPTH = 4
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core_N,
  input  logic [DWIDTH-1:0] Program_Count,
  input  logic              Program_Count_Valid,
  output logic              Program_Count_Ready,
  input  logic              Flush,
  output logic              Imem_Req_Valid,
  input  logic              Imem_Req_Ready,
  output logic [DWIDTH-1:0] Imem_Addr,
  input  logic              Imem_Rsp_Valid,
  input  logic [DWIDTH-1:0] Imem_Rsp_Data,
  output logic              Instr_Valid,
  input  logic              Instr_Ready,
  output logic [DWIDTH-1:0] Instr,
  output logic [DWIDTH-1:0] Instr_PC,
  output logic              Fetch_Misalign
);

  localparam int CW = $clog2(FETCH_DEPTH) + 1;

  fetch_state_t          state_reg;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         outstanding_next;
  logic [CW-1:0]         fifo_count;
  logic                  credit;
  logic                  rsp_take;
  logic                  misalign_block;
  logic                  aq_empty;
  logic                  aq_full;
  logic                  iq_empty;
  logic                  iq_full;
  logic [DWIDTH-1:0]     aq_head;
  logic [2*DWIDTH-1:0]   iq_head;

  // Credit covers both in-flight and buffered entries, so every response is
  // guaranteed a slot in the instruction buffer.
  assign credit = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FETCH_DEPTH);

  assign Imem_Addr           = Program_Count;
  assign Imem_Req_Valid      = Program_Count_Valid & credit & (state_reg == FETCH)
                               & ~Flush & ~misalign_block;
  assign Program_Count_Ready = Imem_Req_Valid & Imem_Req_Ready;

  // Responses with nothing outstanding are stray and are not consumed.
  assign rsp_take         = Imem_Rsp_Valid & ~aq_empty;
  assign outstanding_next = outstanding - CW'(rsp_take);

  fetch_fifo #(
    .DEPTH (FETCH_DEPTH),
    .WIDTH (DWIDTH)
  ) u_addr_q (
    .clk       (Clk_Core),
    .rst_n     (Rst_Core_N),
    .clr       (1'b0),
    .push      (Program_Count_Ready),
    .push_data (Program_Count),
    .pop       (rsp_take),
    .pop_data  (aq_head),
    .count     (outstanding),
    .full      (aq_full),
    .empty     (aq_empty)
  );

  // Responses are buffered only in FETCH and not in the cycle of a redirect;
  // otherwise they belong to the discarded stream.
  fetch_fifo #(
    .DEPTH (FETCH_DEPTH),
    .WIDTH (2*DWIDTH)
  ) u_instr_q (
    .clk       (Clk_Core),
    .rst_n     (Rst_Core_N),
    .clr       (Flush),
    .push      (rsp_take & (state_reg == FETCH) & ~Flush),
    .push_data ({aq_head, Imem_Rsp_Data}),
    .pop       (Instr_Valid & Instr_Ready),
    .pop_data  (iq_head),
    .count     (fifo_count),
    .full      (iq_full),
    .empty     (iq_empty)
  );

  assign Instr_Valid = ~iq_empty;
  assign Instr       = iq_empty ? DWIDTH'(NOP_INSTR) : iq_head[DWIDTH-1:0];
  assign Instr_PC    = iq_empty ? '0 : iq_head[2*DWIDTH-1:DWIDTH];

  // FLUSH lasts until every pre-redirect request has been answered; the
  // decision uses the count after this cycle's response.
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      state_reg <= FETCH;
    end else begin
      case (state_reg)
        FETCH: if (Flush && (outstanding_next != '0)) state_reg <= FLUSH;
        FLUSH: if (outstanding_next == '0)            state_reg <= FETCH;
        default:                                      state_reg <= FETCH;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_hit;
  logic misalign_reg;

  assign misalign_hit   = Program_Count_Valid & (Program_Count[1:0] != 2'b00);
  assign misalign_block = misalign_hit | misalign_reg;
  assign Fetch_Misalign = misalign_reg;

  // Sticky until the redirect that replaces the faulting PC.
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      misalign_reg <= 1'b0;
    end else if (Flush) begin
      misalign_reg <= 1'b0;
    end else if (misalign_hit && (state_reg == FETCH)) begin
      misalign_reg <= 1'b1;
    end
  end
`else
  assign misalign_block = 1'b0;
  assign Fetch_Misalign = 1'b0;
`endif

  logic unused_flags;
  assign unused_flags = &{1'b0, aq_full, iq_full};

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
  import fetch_pkg::*;

  logic        Clk_Core = 1'b0;
  logic        Rst_Core_N;
  logic [31:0] Program_Count;
  logic        Program_Count_Valid;
  logic        Program_Count_Ready;
  logic        Flush;
  logic        Imem_Req_Valid;
  logic        Imem_Req_Ready;
  logic [31:0] Imem_Addr;
  logic        Imem_Rsp_Valid;
  logic [31:0] Imem_Rsp_Data;
  logic        Instr_Valid;
  logic        Instr_Ready;
  logic [31:0] Instr;
  logic [31:0] Instr_PC;
  logic        Fetch_Misalign;

  inst_fetch_unit #(.DWIDTH(32), .FETCH_DEPTH(4)) dut (
    .Clk_Core            (Clk_Core),
    .Rst_Core_N          (Rst_Core_N),
    .Program_Count       (Program_Count),
    .Program_Count_Valid (Program_Count_Valid),
    .Program_Count_Ready (Program_Count_Ready),
    .Flush               (Flush),
    .Imem_Req_Valid      (Imem_Req_Valid),
    .Imem_Req_Ready      (Imem_Req_Ready),
    .Imem_Addr           (Imem_Addr),
    .Imem_Rsp_Valid      (Imem_Rsp_Valid),
    .Imem_Rsp_Data       (Imem_Rsp_Data),
    .Instr_Valid         (Instr_Valid),
    .Instr_Ready         (Instr_Ready),
    .Instr               (Instr),
    .Instr_PC            (Instr_PC),
    .Fetch_Misalign      (Fetch_Misalign)
  );

  always #5 Clk_Core = ~Clk_Core;

  typedef struct {
    logic         pc_valid;
    logic [31:0]  pc;
    logic         req_ready;
    logic         rsp_valid;
    logic [31:0]  rsp_data;
    logic         instr_ready;
    logic         flush;
    logic         exp_req_valid;
    logic         exp_pc_ready;
    logic         exp_ivalid;
    fetch_entry_t exp_entry;
    logic         exp_mis;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic pcv, logic [31:0] pc, logic rr, logic rv,
                              logic [31:0] rd, logic ir, logic fl,
                              logic erv, logic erdy, logic eiv,
                              logic [31:0] ei, logic [31:0] epc,
                              logic emis = 1'b0);
    vec_t v;
    v.pc_valid = pcv; v.pc = pc; v.req_ready = rr; v.rsp_valid = rv;
    v.rsp_data = rd; v.instr_ready = ir; v.flush = fl;
    v.exp_req_valid = erv; v.exp_pc_ready = erdy; v.exp_ivalid = eiv;
    v.exp_entry.instr = ei; v.exp_entry.pc = epc; v.exp_mis = emis;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs are applied just after a rising edge and outputs sampled on the
  // falling edge of the same cycle.
  task automatic do_cycle(string tag, vec_t v);
    Program_Count_Valid = v.pc_valid;
    Program_Count       = v.pc;
    Imem_Req_Ready      = v.req_ready;
    Imem_Rsp_Valid      = v.rsp_valid;
    Imem_Rsp_Data       = v.rsp_data;
    Instr_Ready         = v.instr_ready;
    Flush               = v.flush;
    @(negedge Clk_Core);
    chk({tag, ".req_valid"}, 32'(Imem_Req_Valid), 32'(v.exp_req_valid));
    chk({tag, ".pc_ready"}, 32'(Program_Count_Ready), 32'(v.exp_pc_ready));
    chk({tag, ".instr_valid"}, 32'(Instr_Valid), 32'(v.exp_ivalid));
    chk({tag, ".misalign"}, 32'(Fetch_Misalign), 32'(v.exp_mis));
    if (v.exp_req_valid) chk({tag, ".imem_addr"}, Imem_Addr, v.pc);
    if (v.exp_ivalid) begin
      chk({tag, ".instr"}, Instr, v.exp_entry.instr);
      chk({tag, ".instr_pc"}, Instr_PC, v.exp_entry.pc);
    end
    $display("cyc %s: pcv=%0b pc=%h rsp=%0b ir=%0b fl=%0b -> rdy=%0b iv=%0b instr=%h ipc=%h",
             tag, v.pc_valid, v.pc, v.rsp_valid, v.instr_ready, v.flush,
             Program_Count_Ready, Instr_Valid, Instr, Instr_PC);
    @(posedge Clk_Core);
    #1;
  endtask

  initial begin
    Rst_Core_N = 1'b0;
    Program_Count = '0; Program_Count_Valid = 0; Flush = 0;
    Imem_Req_Ready = 0; Imem_Rsp_Valid = 0; Imem_Rsp_Data = '0; Instr_Ready = 0;

    //             pcv pc       rr rv data          ir fl  erv rdy iv instr         pc
    // reset state / single fetch
    vecs.push_back(mk(0, 32'h0,   1, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 32'h100, 1, 0, 32'h0,         0, 0, 1, 1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 32'h0,   1, 1, 32'h0010_0093, 0, 0, 0, 0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 32'h0,   1, 0, 32'h0,         1, 0, 0, 0, 1, 32'h0010_0093, 32'h100));
    vecs.push_back(mk(0, 32'h0,   1, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0,         32'h0));
    // backpressure: four requests fill the credit, fifth stalls
    vecs.push_back(mk(1, 32'h0,   1, 0, 32'h0,         0, 0, 1, 1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 32'h4,   1, 0, 32'h0,         0, 0, 1, 1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 32'h8,   1, 0, 32'h0,         0, 0, 1, 1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 32'hC,   1, 0, 32'h0,         0, 0, 1, 1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 32'h10,  1, 1, 32'hA000_0000, 0, 0, 0, 0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 32'h10,  1, 1, 32'hA000_0001, 0, 0, 0, 0, 1, 32'hA000_0000, 32'h0));
    vecs.push_back(mk(1, 32'h10,  1, 1, 32'hA000_0002, 0, 0, 0, 0, 1, 32'hA000_0000, 32'h0));
    vecs.push_back(mk(1, 32'h10,  1, 1, 32'hA000_0003, 0, 0, 0, 0, 1, 32'hA000_0000, 32'h0));
    vecs.push_back(mk(1, 32'h10,  1, 0, 32'h0,         0, 0, 0, 0, 1, 32'hA000_0000, 32'h0));
    vecs.push_back(mk(0, 32'h0,   1, 0, 32'h0,         1, 0, 0, 0, 1, 32'hA000_0000, 32'h0));
    // credit full (3 buffered + 1 in flight), then response and pop together
    vecs.push_back(mk(1, 32'h10,  1, 0, 32'h0,         0, 0, 1, 1, 1, 32'hA000_0001, 32'h4));
    vecs.push_back(mk(0, 32'h0,   1, 1, 32'hB000_0000, 1, 0, 0, 0, 1, 32'hA000_0001, 32'h4));
    vecs.push_back(mk(0, 32'h0,   1, 0, 32'h0,         1, 0, 0, 0, 1, 32'hA000_0002, 32'h8));
    vecs.push_back(mk(0, 32'h0,   1, 0, 32'h0,         1, 0, 0, 0, 1, 32'hA000_0003, 32'hC));
    vecs.push_back(mk(0, 32'h0,   1, 0, 32'h0,         1, 0, 0, 0, 1, 32'hB000_0000, 32'h10));
    vecs.push_back(mk(0, 32'h0,   1, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0,         32'h0));
    // flush with two outstanding and one buffered, repeated flush in FLUSH
    vecs.push_back(mk(1, 32'h20,  1, 0, 32'h0,         0, 0, 1, 1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 32'h24,  1, 1, 32'hC000_0000, 0, 0, 1, 1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 32'h28,  1, 0, 32'h0,         0, 0, 1, 1, 1, 32'hC000_0000, 32'h20));
    vecs.push_back(mk(1, 32'h200, 1, 0, 32'h0,         0, 1, 0, 0, 1, 32'hC000_0000, 32'h20));
    vecs.push_back(mk(1, 32'h200, 1, 1, 32'hD000_0000, 0, 1, 0, 0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 32'h200, 1, 1, 32'hD000_0001, 0, 0, 0, 0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 32'h200, 1, 0, 32'h0,         0, 0, 1, 1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 32'h0,   1, 1, 32'hE000_0000, 0, 0, 0, 0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 32'h0,   1, 0, 32'h0,         1, 0, 0, 0, 1, 32'hE000_0000, 32'h200));
    // flush with nothing outstanding stays in FETCH
    vecs.push_back(mk(1, 32'h300, 1, 0, 32'h0,         1, 1, 0, 0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(1, 32'h300, 1, 0, 32'h0,         1, 0, 1, 1, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 32'h0,   1, 1, 32'hE000_0001, 0, 0, 0, 0, 0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 32'h0,   1, 0, 32'h0,         1, 0, 0, 0, 1, 32'hE000_0001, 32'h300));
    vecs.push_back(mk(0, 32'h0,   1, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0,         32'h0));
    // memory not ready: request offered but not accepted
    vecs.push_back(mk(1, 32'h340, 0, 0, 32'h0,         1, 0, 1, 0, 0, 32'h0,         32'h0));

    repeat (3) @(posedge Clk_Core);
    @(negedge Clk_Core);
    chk("reset.instr_valid", 32'(Instr_Valid), 32'h0);
    chk("reset.instr", Instr, NOP_INSTR);
    chk("reset.instr_pc", Instr_PC, 32'h0);
    chk("reset.misalign", 32'(Fetch_Misalign), 32'h0);
    Rst_Core_N = 1'b1;
    @(posedge Clk_Core);
    #1;

    for (int i = 0; i < vecs.size(); i++) do_cycle($sformatf("v%0d", i), vecs[i]);

    // Reset with three entries buffered and one request in flight.
    do_cycle("r0", mk(1, 32'h400, 1, 0, 32'h0,         0, 0, 1, 1, 0, 32'h0, 32'h0));
    do_cycle("r1", mk(1, 32'h404, 1, 1, 32'hF000_0000, 0, 0, 1, 1, 0, 32'h0, 32'h0));
    do_cycle("r2", mk(1, 32'h408, 1, 1, 32'hF000_0001, 0, 0, 1, 1, 1, 32'hF000_0000, 32'h400));
    do_cycle("r3", mk(1, 32'h40C, 1, 1, 32'hF000_0002, 0, 0, 1, 1, 1, 32'hF000_0000, 32'h400));
    Program_Count_Valid = 0; Imem_Rsp_Valid = 0; Instr_Ready = 0;
    Rst_Core_N = 1'b0;
    #1;
    chk("rst_mid.instr_valid", 32'(Instr_Valid), 32'h0);
    chk("rst_mid.instr", Instr, NOP_INSTR);
    chk("rst_mid.instr_pc", Instr_PC, 32'h0);
    $display("cyc rst_mid: iv=%0b instr=%h ipc=%h", Instr_Valid, Instr, Instr_PC);
    @(negedge Clk_Core);
    Rst_Core_N = 1'b1;
    @(posedge Clk_Core);
    #1;
    // stray response for the abandoned 0x40C request must not be stored
    do_cycle("s0", mk(0, 32'h0,   1, 1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 32'h0, 32'h0));
    do_cycle("s1", mk(0, 32'h0,   1, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0, 32'h0));
    do_cycle("s2", mk(1, 32'h500, 1, 0, 32'h0,         1, 0, 1, 1, 0, 32'h0, 32'h0));
    do_cycle("s3", mk(0, 32'h0,   1, 1, 32'h1234_5678, 1, 0, 0, 0, 0, 32'h0, 32'h0));
    do_cycle("s4", mk(0, 32'h0,   1, 0, 32'h0,         1, 0, 0, 0, 1, 32'h1234_5678, 32'h500));

`ifdef FETCH_MISALIGN_CHK_EN
    do_cycle("m0", mk(1, 32'h102, 1, 0, 32'h0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 1'b0));
    do_cycle("m1", mk(1, 32'h104, 1, 0, 32'h0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 1'b1));
    do_cycle("m2", mk(1, 32'h104, 1, 0, 32'h0, 1, 1, 0, 0, 0, 32'h0, 32'h0, 1'b1));
    do_cycle("m3", mk(1, 32'h104, 1, 0, 32'h0, 1, 0, 1, 1, 0, 32'h0, 32'h0, 1'b0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
